// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache: controller state encoding and
// physical-memory address source select codes.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } cache_ctrl_state_t;

    localparam logic [1:0] PMEMADDR_CPU  = 2'b00;
    localparam logic [1:0] PMEMADDR_WAY0 = 2'b01;
    localparam logic [1:0] PMEMADDR_WAY1 = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != 16'hFFFF))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/cache_control.sv
// Control FSM for a 2-way write-back cache: zero-wait hits, optional victim
// writeback, then line fill; the datapath holds all tag/data/valid/dirty state.
module cache_control
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        lru_out,
    input  logic        d_out0,
    input  logic        d_out1,
    output logic        load_lru,
    output logic        writeback_ctrlsig,
    output logic        load_d0,
    output logic        load_v0,
    output logic        load_TD0,
    output logic        d_in0,
    output logic        v_in0,
    output logic        load_d1,
    output logic        load_v1,
    output logic        load_TD1,
    output logic        d_in1,
    output logic        v_in1,
    output logic [1:0]  pmemaddr_sel,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
    output logic [15:0] wb_count
);

    cache_ctrl_state_t state, next_state;

    logic req, hit, victim, victim_dirty;
    logic hit_evt, miss_evt, wb_evt;

    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    assign victim       = lru_out;
    assign victim_dirty = victim ? d_out1 : d_out0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state        = state;
        mem_resp          = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        load_lru          = 1'b0;
        writeback_ctrlsig = 1'b0;
        load_d0           = 1'b0;
        load_v0           = 1'b0;
        load_TD0          = 1'b0;
        d_in0             = 1'b0;
        v_in0             = 1'b0;
        load_d1           = 1'b0;
        load_v1           = 1'b0;
        load_TD1          = 1'b0;
        d_in1             = 1'b0;
        v_in1             = 1'b0;
        pmemaddr_sel      = PMEMADDR_CPU;
        hit_evt           = 1'b0;
        miss_evt          = 1'b0;
        wb_evt            = 1'b0;

        unique case (state)
            IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    hit_evt  = 1'b1;
                    // A simultaneous read+write is a write; only the hitting way is touched.
                    if (mem_write) begin
                        if (hit0) begin
                            load_TD0 = 1'b1;
                            load_d0  = 1'b1;
                            d_in0    = 1'b1;
                            load_v0  = 1'b1;
                            v_in0    = 1'b1;
                        end else begin
                            load_TD1 = 1'b1;
                            load_d1  = 1'b1;
                            d_in1    = 1'b1;
                            load_v1  = 1'b1;
                            v_in1    = 1'b1;
                        end
                    end
                end else if (req) begin
                    miss_evt   = 1'b1;
                    next_state = victim_dirty ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                pmem_write        = 1'b1;
                writeback_ctrlsig = ~victim;
                pmemaddr_sel      = victim ? PMEMADDR_WAY1 : PMEMADDR_WAY0;
                if (pmem_resp) begin
                    wb_evt     = 1'b1;
                    next_state = FILL;
                end
            end

            FILL: begin
                pmem_read    = 1'b1;
                pmemaddr_sel = PMEMADDR_CPU;
                // The line lands clean; a pending write merges on the following IDLE hit.
                if (pmem_resp) begin
                    if (!victim) begin
                        load_TD0 = 1'b1;
                        load_v0  = 1'b1;
                        v_in0    = 1'b1;
                        load_d0  = 1'b1;
                    end else begin
                        load_TD1 = 1'b1;
                        load_v1  = 1'b1;
                        v_in1    = 1'b1;
                        load_d1  = 1'b1;
                    end
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    sat_counter u_hit_cnt  (.clk(clk), .rst_n(rst_n), .inc(hit_evt),  .count(hit_count));
    sat_counter u_miss_cnt (.clk(clk), .rst_n(rst_n), .inc(miss_evt), .count(miss_count));
    sat_counter u_wb_cnt   (.clk(clk), .rst_n(rst_n), .inc(wb_evt),   .count(wb_count));

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed scenarios plus random
// traffic compared cycle by cycle against a phase-level behavioural model.
module tb_cache_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
    logic        hit0 = 1'b0, hit1 = 1'b0, lru_out = 1'b0, d_out0 = 1'b0, d_out1 = 1'b0;
    logic        mem_resp, pmem_read, pmem_write, load_lru, writeback_ctrlsig;
    logic        load_d0, load_v0, load_TD0, d_in0, v_in0;
    logic        load_d1, load_v1, load_TD1, d_in1, v_in1;
    logic [1:0]  pmemaddr_sel;
    logic [15:0] hit_count, miss_count, wb_count;

    typedef struct packed {
        logic       mem_resp, pmem_read, pmem_write, load_lru, wb_sig;
        logic       ld_d0, ld_v0, ld_td0, d0, v0;
        logic       ld_d1, ld_v1, ld_td1, d1, v1;
        logic [1:0] sel;
    } ctl_t;

    ctl_t obs, exp_c;
    assign obs = {mem_resp, pmem_read, pmem_write, load_lru, writeback_ctrlsig,
                  load_d0, load_v0, load_TD0, d_in0, v_in0,
                  load_d1, load_v1, load_TD1, d_in1, v_in1, pmemaddr_sel};

    // Model: phase 0 = waiting for CPU, 1 = writing victim back, 2 = fetching line.
    int ph, m_hit, m_miss, m_wb;
    int errors = 0, checks = 0;

    cache_control dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .hit0(hit0), .hit1(hit1), .lru_out(lru_out),
        .d_out0(d_out0), .d_out1(d_out1), .load_lru(load_lru),
        .writeback_ctrlsig(writeback_ctrlsig),
        .load_d0(load_d0), .load_v0(load_v0), .load_TD0(load_TD0), .d_in0(d_in0), .v_in0(v_in0),
        .load_d1(load_d1), .load_v1(load_v1), .load_TD1(load_TD1), .d_in1(d_in1), .v_in1(v_in1),
        .pmemaddr_sel(pmemaddr_sel), .hit_count(hit_count), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic ctl_t model_ctl();
        ctl_t c = '0;
        logic req = mem_read | mem_write;
        case (ph)
            0: if (req && (hit0 || hit1)) begin
                c.mem_resp = 1; c.load_lru = 1;
                if (mem_write) begin
                    if (hit0) {c.ld_td0, c.ld_d0, c.d0, c.ld_v0, c.v0} = 5'b11111;
                    else      {c.ld_td1, c.ld_d1, c.d1, c.ld_v1, c.v1} = 5'b11111;
                end
            end
            1: begin
                c.pmem_write = 1;
                c.wb_sig = (lru_out == 1'b0);
                c.sel = lru_out ? 2'b10 : 2'b01;
            end
            default: begin
                c.pmem_read = 1;
                if (pmem_resp) begin
                    if (!lru_out) {c.ld_td0, c.ld_v0, c.v0, c.ld_d0} = 4'b1111;
                    else          {c.ld_td1, c.ld_v1, c.v1, c.ld_d1} = 4'b1111;
                end
            end
        endcase
        return c;
    endfunction

    // Apply inputs just after an edge, then wait to mid-cycle for sampling.
    task automatic drive(input logic rd, wr, h0, h1, lru, dd0, dd1, pr);
        {mem_read, mem_write, hit0, hit1, lru_out, d_out0, d_out1, pmem_resp} =
            {rd, wr, h0, h1, lru, dd0, dd1, pr};
        exp_c = model_ctl();
        @(negedge clk);
    endtask

    // Advance the model by one clock using the currently applied inputs.
    task automatic step();
        logic req = mem_read | mem_write;
        case (ph)
            0: if (req && (hit0 || hit1)) m_hit = sat(m_hit + 1);
               else if (req) begin
                   m_miss = sat(m_miss + 1);
                   ph = (lru_out ? d_out1 : d_out0) ? 1 : 2;
               end
            1: if (pmem_resp) begin m_wb = sat(m_wb + 1); ph = 2; end
            default: if (pmem_resp) ph = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {mem_read, mem_write, hit0, hit1, lru_out, d_out0, d_out1, pmem_resp} = '0;
        rst_n = 1'b0;
        ph = 0; m_hit = 0; m_miss = 0; m_wb = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {mem_read, mem_write, hit0, hit1, lru_out, d_out0, d_out1, pmem_resp} = '0;
        ph = 0; m_hit = 0; m_miss = 0; m_wb = 0;
        @(negedge clk);
        checks++;
        if (obs !== '0 || hit_count !== 16'd0 || miss_count !== 16'd0 || wb_count !== 16'd0) begin
            errors++;
            $display("FAIL reset: ctl=%h cnt=%0d/%0d/%0d want all 0", obs, hit_count, miss_count, wb_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL post_reset_idle: ctl=%h want 0", obs); end
        step();
    endtask

    task automatic test_read_hit_way1();
        do_reset();
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_c || !mem_resp || !load_lru || load_TD0 || load_TD1) begin
            errors++; $display("FAIL read_hit_way1: ctl=%h want %h", obs, exp_c);
        end
        step();
        checks++;
        if (hit_count !== 16'd1) begin errors++; $display("FAIL read_hit_count: got %0d want 1", hit_count); end
    endtask

    task automatic test_write_hit_way0();
        do_reset();
        drive(0, 1, 1, 0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_c || !load_TD0 || !load_d0 || !d_in0 || !mem_resp ||
            {load_d1, load_v1, load_TD1, d_in1, v_in1} !== 5'b0) begin
            errors++; $display("FAIL write_hit_way0: ctl=%h want %h", obs, exp_c);
        end
        step();
        // Read and write together behave as a write.
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_c || !d_in1 || !load_d1) begin
            errors++; $display("FAIL rd_wr_as_write: ctl=%h want %h", obs, exp_c);
        end
        step();
    endtask

    task automatic test_clean_read_miss();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL clean_miss_idle: ctl=%h want 0", obs); end
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== exp_c || !pmem_read || pmem_write || pmemaddr_sel !== 2'b00 || load_TD0) begin
                errors++; $display("FAIL fill_wait[%0d]: ctl=%h want %h", i, obs, exp_c);
            end
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== exp_c || !load_TD0 || !load_v0 || !v_in0 || d_in0 || load_TD1) begin
            errors++; $display("FAIL fill_done: ctl=%h want %h", obs, exp_c);
        end
        step();
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_c || !mem_resp || miss_count !== 16'd1) begin
            errors++; $display("FAIL miss_completes: ctl=%h miss=%0d want %h miss=1", obs, miss_count, exp_c);
        end
        step();
    endtask

    task automatic test_dirty_write_miss();
        do_reset();
        drive(0, 1, 0, 0, 1, 0, 1, 0);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL dirty_miss_idle: ctl=%h want 0", obs); end
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 1, 0, 1, (i == 2));
            checks++;
            if (obs !== exp_c || !pmem_write || pmem_read || pmemaddr_sel !== 2'b10 || writeback_ctrlsig) begin
                errors++; $display("FAIL writeback[%0d]: ctl=%h want %h", i, obs, exp_c);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 1, 0, 0, (i == 1));
            checks++;
            if (obs !== exp_c || !pmem_read || pmem_write) begin
                errors++; $display("FAIL wb_fill[%0d]: ctl=%h want %h", i, obs, exp_c);
            end
            step();
        end
        drive(0, 1, 0, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_c || !mem_resp || !d_in1 || !load_d1 || wb_count !== 16'd1) begin
            errors++; $display("FAIL dirty_miss_merge: ctl=%h wb=%0d want %h wb=1", obs, wb_count, exp_c);
        end
        step();
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pmem_read !== 1'b1) begin errors++; $display("FAIL pre_reset_fill: pmem_read=%b want 1", pmem_read); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || miss_count !== 16'd0) begin
            errors++; $display("FAIL async_reset: rd=%b wr=%b miss=%0d want 0/0/0", pmem_read, pmem_write, miss_count);
        end
        ph = 0; m_hit = 0; m_miss = 0; m_wb = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL idle_after_reset: ctl=%h want 0", obs); end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int h = $urandom_range(0, 2);
            drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0), (h == 1), (h == 2),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0));
            checks++;
            if (obs !== exp_c) begin errors++; $display("FAIL random_ctl[%0d]: ctl=%h want %h", i, obs, exp_c); end
            checks++;
            if (hit_count !== 16'(m_hit) || miss_count !== 16'(m_miss) || wb_count !== 16'(m_wb)) begin
                errors++;
                $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        {mem_read, hit0} = 2'b11;
        for (int i = 0; i < 65534; i++) step();
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (hit_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h want fffe", hit_count); end
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1, 0, 1, 0, 0, 0, 0, 0);
            checks++;
            if (hit_count !== 16'(m_hit) || hit_count !== 16'hFFFF) begin
                errors++; $display("FAIL sat_hold[%0d]: got %h want ffff", i, hit_count);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_read_hit_way1();
        test_write_hit_way0();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_reset_mid_fill();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
